// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: state encoding, width helper and default timing for the PLL lock supervisor
package pll_sup_pkg;
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_PD        = 3'd1;
   localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
   localparam logic [2:0] ST_STABLE    = 3'd3;
   localparam logic [2:0] ST_LOCKED    = 3'd4;
   localparam logic [2:0] ST_FAULT     = 3'd5;
   localparam int DEF_N_PLL         = 2;
   localparam int DEF_CNT_W         = 16;
   localparam int DEF_PD_CYCLES     = 64;
   localparam int DEF_LOCK_TIMEOUT  = 4096;
   localparam int DEF_STABLE_CYCLES = 1024;
   localparam int DEF_MAX_RETRIES   = 3;
   localparam int DEF_LOSS_W        = 8;
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction
endpackage

// File: rtl/pll_sup_channel.sv
// pll_sup_channel: power-down sequencing, lock debounce, retry and loss counting for one PLL
module pll_sup_channel
   import pll_sup_pkg::*;
#(
   parameter int CNT_W         = DEF_CNT_W,
   parameter int PD_CYCLES     = DEF_PD_CYCLES,
   parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
   parameter int LOSS_W        = DEF_LOSS_W
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_enable,
   input  logic              i_restart,
   input  logic              i_pll_lock,
   output logic              o_pll_powerdown_n,
   output logic              o_ready,
   output logic              o_fault,
   output logic              o_ready_nxt,
   output logic [LOSS_W-1:0] o_loss_count
);
   localparam int RET_W = cnt_width(MAX_RETRIES);
   localparam logic [CNT_W-1:0]  PD_LAST = CNT_W'(PD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  ST_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RET_W-1:0]  RET_MAX = RET_W'(MAX_RETRIES);
   localparam logic [LOSS_W-1:0] LOSS_MAX = '1;
   logic [1:0]        r_sync;
   logic [2:0]        r_state, w_state_n;
   logic [CNT_W-1:0]  r_tmr, w_tmr_n;
   logic [RET_W-1:0]  r_retry, w_retry_n;
   logic [LOSS_W-1:0] r_loss, w_loss_n;
   logic              r_pd_n, r_ready, r_fault;
   logic              w_lock_s;
   assign w_lock_s = r_sync[1];
   // next-state: disable beats restart, restart beats lock/timer events
   always_comb begin
      w_state_n = r_state;
      w_tmr_n   = r_tmr + 1'b1;
      w_retry_n = r_retry;
      w_loss_n  = r_loss;
      if (!i_enable) begin
         w_state_n = ST_IDLE;
         w_tmr_n   = '0;
         w_retry_n = '0;
      end else if (i_restart && r_state != ST_IDLE) begin
         w_state_n = ST_PD;
         w_tmr_n   = '0;
         w_retry_n = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_n = ST_PD;
               w_tmr_n   = '0;
            end
            ST_PD: if (r_tmr == PD_LAST) begin
               w_state_n = ST_WAIT_LOCK;
               w_tmr_n   = '0;
            end
            ST_WAIT_LOCK: if (w_lock_s) begin
               w_state_n = ST_STABLE;
               w_tmr_n   = '0;
            end else if (r_tmr == TO_LAST) begin
               w_tmr_n   = '0;
               w_state_n = (r_retry < RET_MAX) ? ST_PD : ST_FAULT;
               w_retry_n = (r_retry < RET_MAX) ? r_retry + 1'b1 : r_retry;
            end
            ST_STABLE: if (!w_lock_s) begin
               w_state_n = ST_WAIT_LOCK;
               w_tmr_n   = '0;
            end else if (r_tmr == ST_LAST) begin
               w_state_n = ST_LOCKED;
               w_tmr_n   = '0;
               w_retry_n = '0;
            end
            ST_LOCKED: begin
               w_tmr_n   = '0;
               w_state_n = w_lock_s ? ST_LOCKED : ST_PD;
               w_loss_n  = (!w_lock_s && r_loss != LOSS_MAX) ? r_loss + 1'b1 : r_loss;
            end
            default: begin
               w_state_n = ST_FAULT;
               w_tmr_n   = '0;
            end
         endcase
      end
   end
   // state, counters and outputs registered from the next state so they change on the deciding edge
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync  <= '0;
         r_state <= ST_IDLE;
         r_tmr   <= '0;
         r_retry <= '0;
         r_loss  <= '0;
         r_pd_n  <= 1'b0;
         r_ready <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_pll_lock};
         r_state <= w_state_n;
         r_tmr   <= w_tmr_n;
         r_retry <= w_retry_n;
         r_loss  <= w_loss_n;
         r_pd_n  <= w_state_n inside {ST_WAIT_LOCK, ST_STABLE, ST_LOCKED};
         r_ready <= w_state_n == ST_LOCKED;
         r_fault <= w_state_n == ST_FAULT;
      end
   end
   assign o_pll_powerdown_n = r_pd_n;
   assign o_ready           = r_ready;
   assign o_fault           = r_fault;
   assign o_ready_nxt       = !i_rst && w_state_n == ST_LOCKED;
   assign o_loss_count      = r_loss;
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: independent per-PLL supervisors plus the combined ready flag
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int N_PLL         = DEF_N_PLL,
   parameter int CNT_W         = DEF_CNT_W,
   parameter int PD_CYCLES     = DEF_PD_CYCLES,
   parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
   parameter int LOSS_W        = DEF_LOSS_W
)(
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [N_PLL-1:0]        i_enable,
   input  logic [N_PLL-1:0]        i_restart,
   input  logic [N_PLL-1:0]        i_pll_lock,
   output logic [N_PLL-1:0]        o_pll_powerdown_n,
   output logic [N_PLL-1:0]        o_ready,
   output logic [N_PLL-1:0]        o_fault,
   output logic                    o_all_ready,
   output logic [N_PLL*LOSS_W-1:0] o_loss_count
);
   logic [N_PLL-1:0] w_ready_nxt;
   logic             r_all_ready;
   genvar g;
   generate
      for (g = 0; g < N_PLL; g++) begin : g_ch
         pll_sup_channel #(
            .CNT_W(CNT_W), .PD_CYCLES(PD_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
            .STABLE_CYCLES(STABLE_CYCLES), .MAX_RETRIES(MAX_RETRIES), .LOSS_W(LOSS_W)
         ) u_ch (
            .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable[g]), .i_restart(i_restart[g]),
            .i_pll_lock(i_pll_lock[g]), .o_pll_powerdown_n(o_pll_powerdown_n[g]),
            .o_ready(o_ready[g]), .o_fault(o_fault[g]), .o_ready_nxt(w_ready_nxt[g]),
            .o_loss_count(o_loss_count[g*LOSS_W +: LOSS_W])
         );
      end
   endgenerate
   // every enabled channel about to be ready, and at least one enabled
   always_ff @(posedge i_clk) begin
      r_all_ready <= i_rst ? 1'b0 : (|i_enable) && (&(w_ready_nxt | ~i_enable));
   end
   assign o_all_ready = r_all_ready;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed scenarios plus random traffic against a phase/age reference model
module tb_pll_lock_supervisor;
   localparam int N = 2, CW = 16, PDC = 4, TO = 20, STC = 8, MR = 2, LW = 8, MAXC = 32768;
   typedef enum int {M_IDLE, M_PD, M_WAIT, M_STABLE, M_LOCKED, M_FAULT} mph_t;
   typedef struct packed {
      logic [N-1:0]    pd_n;
      logic [N-1:0]    ready;
      logic [N-1:0]    fault;
      logic            all_ready;
      logic [N*LW-1:0] loss;
   } obs_t;
   logic clk = 1'b0, rst = 1'b1;
   logic [N-1:0] en = '0, rs = '0, lk = '0;
   logic [N-1:0] o_pd_n, o_ready, o_fault;
   logic o_all;
   logic [N*LW-1:0] o_loss;
   int tests = 0, errors = 0, k = 0, rst_edge = 0;
   mph_t ph [N];
   int entry [N], retries [N], loss [N];
   bit [N-1:0] hist [MAXC];
   bit [N-1:0] rnd_on = '0;
   obs_t exp_q [$];
   obs_t m_e, m_a;
   always #5 clk = ~clk;
   pll_lock_supervisor #(
      .N_PLL(N), .CNT_W(CW), .PD_CYCLES(PDC), .LOCK_TIMEOUT(TO),
      .STABLE_CYCLES(STC), .MAX_RETRIES(MR), .LOSS_W(LW)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_enable(en), .i_restart(rs), .i_pll_lock(lk),
      .o_pll_powerdown_n(o_pd_n), .o_ready(o_ready), .o_fault(o_fault),
      .o_all_ready(o_all), .o_loss_count(o_loss)
   );
   function automatic void go(input int c, input mph_t p);
      ph[c] = p;
      entry[c] = k;
   endfunction
   // reference: each phase lasts a fixed age measured in edges; lock is seen two samples late
   function automatic void model_step();
      obs_t want;
      bit ls, all;
      int age;
      k++;
      hist[k] = lk;
      if (rst) rst_edge = k;
      for (int c = 0; c < N; c++) begin
         ls = (k - 2 > rst_edge) ? hist[k-2][c] : 1'b0;
         age = k - entry[c];
         if (rst) begin
            go(c, M_IDLE); retries[c] = 0; loss[c] = 0;
         end else if (!en[c]) begin
            go(c, M_IDLE); retries[c] = 0;
         end else if (rs[c] && ph[c] != M_IDLE) begin
            go(c, M_PD); retries[c] = 0;
         end else begin
            case (ph[c])
               M_IDLE:   go(c, M_PD);
               M_PD:     if (age == PDC) go(c, M_WAIT);
               M_WAIT:   if (ls) go(c, M_STABLE);
                         else if (age == TO) begin
                            if (retries[c] < MR) begin retries[c]++; go(c, M_PD); end
                            else go(c, M_FAULT);
                         end
               M_STABLE: if (!ls) go(c, M_WAIT);
                         else if (age == STC) begin go(c, M_LOCKED); retries[c] = 0; end
               M_LOCKED: if (!ls) begin
                            loss[c] = (loss[c] < (1 << LW) - 1) ? loss[c] + 1 : loss[c];
                            go(c, M_PD);
                         end
               default:  ;
            endcase
         end
      end
      want = '0;
      all = (en != '0);
      for (int c = 0; c < N; c++) begin
         want.pd_n[c]  = ph[c] inside {M_WAIT, M_STABLE, M_LOCKED};
         want.ready[c] = ph[c] == M_LOCKED;
         want.fault[c] = ph[c] == M_FAULT;
         want.loss[c*LW +: LW] = LW'(loss[c]);
         if (en[c] && ph[c] != M_LOCKED) all = 1'b0;
      end
      want.all_ready = all;
      exp_q.push_back(want);
   endfunction
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         if (k >= MAXC - 2) begin
            $display("FAIL cycle_budget: got %0d edges, limit %0d", k, MAXC);
            $fatal(1);
         end
         model_step();
         #1;
         for (int c = 0; c < N; c++) if (rnd_on[c]) begin
            if ($urandom_range(15) == 0) lk[c] = ~lk[c];
            rs[c] = ($urandom_range(47) == 0);
            if ($urandom_range(199) == 0) en[c] = ~en[c];
         end
      end
   endtask
   task automatic chk(input string name, input int act, input int want);
      tests++;
      if (act != want) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, want);
      end
   endtask
   task automatic wait_ph(input int c, input mph_t p, input int lim);
      int n = 0;
      while (ph[c] != p && n < lim) begin cyc(1); n++; end
      chk("wait_model_phase", int'(ph[c] == p), 1);
   endtask
   task automatic until_ready(input int c, input int lim, output int n);
      n = 0;
      while (!o_ready[c] && n < lim) begin cyc(1); n++; end
   endtask
   // scoreboard monitor: one expected observation per edge, checked mid-cycle
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         m_e = exp_q.pop_front();
         m_a = {o_pd_n, o_ready, o_fault, o_all, o_loss};
         tests++;
         if (m_a !== m_e) begin
            errors++;
            $display("FAIL outputs @edge %0d: got pd_n=%b ready=%b fault=%b all=%b loss=%h, want pd_n=%b ready=%b fault=%b all=%b loss=%h",
                     k, m_a.pd_n, m_a.ready, m_a.fault, m_a.all_ready, m_a.loss,
                     m_e.pd_n, m_e.ready, m_e.fault, m_e.all_ready, m_e.loss);
         end
      end
   end
   initial begin
      int n;
      cyc(3);
      chk("rst_pd_n", int'(o_pd_n), 0);
      chk("rst_ready", int'(o_ready), 0);
      chk("rst_fault", int'(o_fault), 0);
      chk("rst_all_ready", int'(o_all), 0);
      chk("rst_loss", int'(o_loss), 0);
      rst = 1'b0;
      en[0] = 1'b1;
      n = 0;
      while (!o_pd_n[0] && n < 50) begin cyc(1); n++; end
      chk("enable_to_pd_n_high", n, 5);
      cyc(2);
      lk[0] = 1'b1;
      until_ready(0, 100, n);
      chk("lock_to_ready", n, 11);
      chk("all_ready_single_enabled", int'(o_all), 1);
      en[1] = 1'b1;
      rnd_on[1] = 1'b1;
      rs[0] = 1'b1; cyc(1); rs[0] = 1'b0;
      chk("restart_drops_ready", int'(o_ready[0]), 0);
      wait_ph(0, M_STABLE, 30);
      cyc(3); lk[0] = 1'b0; cyc(3); lk[0] = 1'b1;
      until_ready(0, 100, n);
      chk("glitch_ready_delay", n, 11);
      lk[0] = 1'b0;
      n = 0;
      while (!o_fault[0] && n < 200) begin cyc(1); n++; end
      chk("timeout_to_fault", n, 75);
      chk("fault_pd_n_low", int'(o_pd_n[0]), 0);
      chk("loss_after_drop", int'(o_loss[LW-1:0]), 1);
      cyc(10);
      chk("fault_sticky", int'(o_fault[0]), 1);
      rs[0] = 1'b1; cyc(1); rs[0] = 1'b0;
      chk("restart_clears_fault", int'(o_fault[0]), 0);
      chk("restart_pd_n_low", int'(o_pd_n[0]), 0);
      lk[0] = 1'b1;
      until_ready(0, 100, n);
      chk("recover_ready", int'(o_ready[0]), 1);
      lk[0] = 1'b0; cyc(2); rs[0] = 1'b1; cyc(1); rs[0] = 1'b0;
      chk("restart_vs_loss_count", int'(o_loss[LW-1:0]), 1);
      chk("restart_vs_loss_ready", int'(o_ready[0]), 0);
      for (int i = 0; i < 300; i++) begin
         lk[0] = 1'b1;
         until_ready(0, 100, n);
         chk("loss_loop_ready", int'(o_ready[0]), 1);
         lk[0] = 1'b0;
         cyc(3);
      end
      chk("loss_saturated", int'(o_loss[LW-1:0]), 255);
      chk("loss_ready_low", int'(o_ready[0]), 0);
      wait_ph(0, M_WAIT, 30);
      cyc(3);
      rst = 1'b1; cyc(1);
      chk("rst_mid_pd_n", int'(o_pd_n), 0);
      chk("rst_mid_ready", int'(o_ready), 0);
      chk("rst_mid_fault", int'(o_fault), 0);
      chk("rst_mid_all_ready", int'(o_all), 0);
      chk("rst_mid_loss", int'(o_loss), 0);
      rst = 1'b0;
      en = '1;
      rnd_on = '1;
      cyc(4000);
      rnd_on = '0; en = '0; rs = '0;
      cyc(2);
      @(negedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
